// File: rtl/gpmc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpmc_pkg
// Purpose  : Shared definitions for the GPMC bus master. This package holds
//            the FSM state encoding, the address/data bus width and the
//            default number of data-phase cycles.
// Revision : 1.0  initial release
// ============================================================================
package gpmc_pkg;

  localparam int AD_W         = 16;
  localparam int WAIT_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_HOLD = 3'd2,
    DATA      = 3'd3,
    TURN      = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gpmc_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : gpmc_clk_gen
// Purpose  : Divides the system clock by two to produce the GPMC bus clock.
//            It also flags the "tick", which is the system edge on which the
//            bus clock falls.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            gpmc_clk - registered bus clock, 0 in reset
//            tick     - high during the cycle that ends in a 1->0 bus edge
// Revision : 1.0  initial release
// ============================================================================
module gpmc_clk_gen (
  input  logic clk,
  input  logic rst_n,
  output logic gpmc_clk,
  output logic tick
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gpmc_clk <= 1'b0;
    else        gpmc_clk <= ~gpmc_clk;
  end

  // The bus clock is high now, so the next system edge drives it low.
  assign tick = gpmc_clk;

endmodule
`default_nettype wire

// File: rtl/gpmc_master.sv
`default_nettype none
// ============================================================================
// Module   : gpmc_master
// Purpose  : Single-word GPMC master for a multiplexed address/data bus. The
//            access sequence is ADDR, ADDR_HOLD, DATA (WAIT_CYC bus periods)
//            and TURN. Bus outputs change only on ticks, which are the falling
//            edges of GPMC_CLK.
// Ports    : OSC_FPGA  - system clock      RESETN    - async active-low reset
//            req_*     - request handshake and captured access fields
//            rsp_valid - 1-cycle completion pulse, rsp_rdata - read data
//            GPMC_CLK  - bus clock (OSC/2) GPMC_*N   - active-low strobes
//            GPMC_AD   - tristate multiplexed address/data bus
// Revision : 1.0  initial release
// ============================================================================
module gpmc_master
  import gpmc_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF  // legal range 1..15
) (
  input  logic            OSC_FPGA,
  input  logic            RESETN,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AD_W-1:0] req_addr,
  input  logic [AD_W-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [AD_W-1:0] rsp_rdata,
  output logic            GPMC_CLK,
  output logic            GPMC_CSN,
  output logic            GPMC_ADVN,
  output logic            GPMC_OEN,
  output logic            GPMC_WEN,
  inout  wire  [AD_W-1:0] GPMC_AD
);

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            tick;
  logic            started;   // keeps req_ready low until one edge after reset
  logic            pending;   // request accepted, waiting for the next tick
  logic            acc_we;
  logic [AD_W-1:0] acc_addr;
  logic [AD_W-1:0] acc_wdata;
  logic            ad_oe;
  logic [AD_W-1:0] ad_out;
  logic            accept;
  logic            data_last;

  gpmc_clk_gen u_clk_gen (
    .clk      (OSC_FPGA),
    .rst_n    (RESETN),
    .gpmc_clk (GPMC_CLK),
    .tick     (tick)
  );

  // Once a request is pending, the block refuses new ones until the access
  // finishes, even while it stays in IDLE.
  assign req_ready = (state == IDLE) && started && !pending;
  assign accept    = req_valid && req_ready;
  assign data_last = (state == DATA) && tick && (cnt == 4'd1);

  always_ff @(posedge OSC_FPGA or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      started   <= 1'b0;
      pending   <= 1'b0;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      started   <= 1'b1;
      rsp_valid <= (state == TURN) && tick;
      if (accept) begin
        pending   <= 1'b1;
        acc_we    <= req_we;
        acc_addr  <= req_addr;
        acc_wdata <= req_wdata;
      end else if (state == IDLE && tick && pending) begin
        pending <= 1'b0;
      end
      if (state == ADDR_HOLD && tick)
        cnt <= 4'(WAIT_CYC);
      else if (state == DATA && tick)
        cnt <= cnt - 4'd1;
      if (data_last && !acc_we)
        rsp_rdata <= GPMC_AD;
    end
  end

  // The strobes decode directly from the state register. State only changes
  // on ticks, so the strobes do too.
  always_comb begin
    state_nxt = state;
    GPMC_CSN  = 1'b1;
    GPMC_ADVN = 1'b1;
    GPMC_OEN  = 1'b1;
    GPMC_WEN  = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = acc_addr;
    case (state)
      IDLE: begin
        if (tick && pending) state_nxt = ADDR;
      end
      ADDR: begin
        GPMC_CSN  = 1'b0;
        GPMC_ADVN = 1'b0;
        ad_oe     = 1'b1;
        if (tick) state_nxt = ADDR_HOLD;
      end
      ADDR_HOLD: begin
        GPMC_CSN = 1'b0;
        ad_oe    = 1'b1;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        GPMC_CSN = 1'b0;
        if (acc_we) begin
          GPMC_WEN = 1'b0;
          ad_oe    = 1'b1;
          ad_out   = acc_wdata;
        end else begin
          GPMC_OEN = 1'b0;
        end
        if (data_last) state_nxt = TURN;
      end
      TURN: begin
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign GPMC_AD = ad_oe ? ad_out : {AD_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_gpmc_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpmc_master
// Purpose  : Directed self-checking bench for gpmc_master. It instantiates
//            WAIT_CYC=2 with a read responder, plus WAIT_CYC=1 and 15 for
//            measuring access length.
// Revision : 1.0  initial release
// ============================================================================
module tb_gpmc_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        gclk, csn, advn, oen, wen;
  wire  [15:0] gad;
  logic [15:0] resp_data;

  logic        valid_ab, ready_a, ready_b, rsp_a, rsp_b;
  logic [15:0] rdata_a, rdata_b;
  logic        gclk_a, csn_a, advn_a, oen_a, wen_a;
  logic        gclk_b, csn_b, advn_b, oen_b, wen_b;
  wire  [15:0] ad_a, ad_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Responder: it drives read data whenever the master asserts OEN.
  assign gad = !oen ? resp_data : 16'hzzzz;

  gpmc_master #(.WAIT_CYC(2)) dut (
    .OSC_FPGA(clk), .RESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .GPMC_CLK(gclk), .GPMC_CSN(csn), .GPMC_ADVN(advn),
    .GPMC_OEN(oen), .GPMC_WEN(wen), .GPMC_AD(gad)
  );

  gpmc_master #(.WAIT_CYC(1)) dut_a (
    .OSC_FPGA(clk), .RESETN(rst_n),
    .req_valid(valid_ab), .req_ready(ready_a), .req_we(1'b1),
    .req_addr(16'h0100), .req_wdata(16'h0A0A),
    .rsp_valid(rsp_a), .rsp_rdata(rdata_a),
    .GPMC_CLK(gclk_a), .GPMC_CSN(csn_a), .GPMC_ADVN(advn_a),
    .GPMC_OEN(oen_a), .GPMC_WEN(wen_a), .GPMC_AD(ad_a)
  );

  gpmc_master #(.WAIT_CYC(15)) dut_b (
    .OSC_FPGA(clk), .RESETN(rst_n),
    .req_valid(valid_ab), .req_ready(ready_b), .req_we(1'b1),
    .req_addr(16'h0200), .req_wdata(16'h0B0B),
    .rsp_valid(rsp_b), .rsp_rdata(rdata_b),
    .GPMC_CLK(gclk_b), .GPMC_CSN(csn_b), .GPMC_ADVN(advn_b),
    .GPMC_OEN(oen_b), .GPMC_WEN(wen_b), .GPMC_AD(ad_b)
  );

  // Bus monitor. It samples on the falling system edge, away from the edge
  // that updates the outputs. Counts are in system clock cycles.
  int          csn_lo, advn_lo, wen_lo, oen_lo, rsp_cnt, wen_chg;
  int          csn_hi_run, last_gap, csn_a_lo, csn_b_lo, rsp_ab;
  logic [15:0] advn_ad, wen_ad, oen_ad;

  always @(negedge clk) begin
    if (!csn) begin
      if (csn_hi_run > 0) last_gap = csn_hi_run;
      csn_hi_run = 0;
      csn_lo++;
    end else begin
      csn_hi_run++;
    end
    if (!advn) begin advn_lo++; advn_ad = gad; end
    if (!wen) begin
      if (wen_lo > 0 && gad != wen_ad) wen_chg++;
      wen_ad = gad;
      wen_lo++;
    end
    if (!oen) begin oen_lo++; oen_ad = gad; end
    if (rsp_valid) rsp_cnt++;
    if (!csn_a) csn_a_lo++;
    if (!csn_b) csn_b_lo++;
    if (rsp_a) rsp_ab++;
    if (rsp_b) rsp_ab++;
  end

  task automatic clr_mon();
    csn_lo = 0; advn_lo = 0; wen_lo = 0; oen_lo = 0; rsp_cnt = 0;
    wen_chg = 0; csn_a_lo = 0; csn_b_lo = 0; rsp_ab = 0;
    advn_ad = '0; wen_ad = '0; oen_ad = '0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request and wait until it is accepted.
  task automatic send_req(input logic we, input logic [15:0] a,
                          input logic [15:0] d);
    bit ok = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check_val("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output logic [15:0] rd);
    bit ok = 0;
    rd = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; rd = rsp_rdata; break; end
    end
    check_val("rsp_timeout", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_access(input logic we, input logic [15:0] a,
                           input logic [15:0] d, input bit mid_change,
                           output logic [15:0] rd);
    send_req(we, a, d);
    req_valid = 1'b0;
    if (mid_change) begin
      req_we = ~we; req_addr = 16'hFFFF; req_wdata = 16'h0000;
    end
    wait_rsp(rd);
  endtask

  logic [15:0] rd;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; valid_ab = 1'b0;
    resp_data = 16'h1234; csn_hi_run = 0; last_gap = 0;
    clr_mon();

    // Values held while reset is asserted.
    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rdata", 32'(rsp_rdata), 32'h0);
    check_val("rst_strobes", {28'd0, csn, advn, oen, wen}, 32'hF);
    check_val("rst_gclk", 32'(gclk), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("ready_after_rst", 32'(req_ready), 32'd1);

    // Write 0010/A5A5: 4 bus periods of CSN, 1 of ADVN, 2 of WEN.
    clr_mon();
    do_access(1'b1, 16'h0010, 16'hA5A5, 1'b0, rd);
    check_val("wr_csn_len", csn_lo, 8);
    check_val("wr_advn_len", advn_lo, 2);
    check_val("wr_addr", 32'(advn_ad), 32'h0010);
    check_val("wr_wen_len", wen_lo, 4);
    check_val("wr_data", 32'(wen_ad), 32'hA5A5);
    check_val("wr_data_stable", wen_chg, 0);
    check_val("wr_oen_len", oen_lo, 0);
    check_val("wr_rsp_cnt", rsp_cnt, 1);

    // Read 0012. The responder returns 1234.
    clr_mon();
    do_access(1'b0, 16'h0012, 16'hDEAD, 1'b0, rd);
    check_val("rd_rdata", 32'(rd), 32'h1234);
    check_val("rd_addr", 32'(advn_ad), 32'h0012);
    check_val("rd_oen_len", oen_lo, 4);
    check_val("rd_bus_data", 32'(oen_ad), 32'h1234);
    check_val("rd_wen_len", wen_lo, 0);
    check_val("rd_rsp_cnt", rsp_cnt, 1);

    // A write must leave the last read data untouched.
    do_access(1'b1, 16'h0040, 16'h5555, 1'b0, rd);
    check_val("rdata_hold", 32'(rsp_rdata), 32'h1234);

    // Back-to-back writes with req_valid held through the first access.
    clr_mon();
    send_req(1'b1, 16'h0020, 16'h0001);
    req_addr = 16'h0022; req_wdata = 16'h0002;
    send_req(1'b1, 16'h0022, 16'h0002);
    req_valid = 1'b0;
    wait_rsp(rd);
    check_val("b2b_rsp_cnt", rsp_cnt, 2);
    check_val("b2b_csn_len", csn_lo, 16);
    check_val("b2b_gap", last_gap, 4);
    check_val("b2b_addr2", 32'(advn_ad), 32'h0022);
    check_val("b2b_data2", 32'(wen_ad), 32'h0002);

    // Request fields change mid-access, but the bus keeps the captured values.
    clr_mon();
    do_access(1'b1, 16'h0030, 16'hBEEF, 1'b1, rd);
    check_val("mid_addr", 32'(advn_ad), 32'h0030);
    check_val("mid_data", 32'(wen_ad), 32'hBEEF);
    check_val("mid_wen_len", wen_lo, 4);
    check_val("mid_oen_len", oen_lo, 0);

    // Reset asserted during the DATA phase of a write.
    clr_mon();
    send_req(1'b1, 16'h0050, 16'h1111);
    req_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!wen) break;
    end
    check_val("abort_in_data", 32'(wen), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("abort_strobes", {28'd0, csn, advn, oen, wen}, 32'hF);
    check_val("abort_gclk", 32'(gclk), 32'd0);
    check_val("abort_ready", 32'(req_ready), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("abort_no_rsp", rsp_cnt, 0);
    clr_mon();
    do_access(1'b0, 16'h0012, 16'h0000, 1'b0, rd);
    check_val("post_rst_rdata", 32'(rd), 32'h1234);
    check_val("post_rst_addr", 32'(advn_ad), 32'h0012);
    check_val("post_rst_csn_len", csn_lo, 8);

    // Extreme WAIT_CYC values: CSN is low for 3 and 17 bus periods.
    clr_mon();
    @(negedge clk);
    valid_ab = 1'b1;
    check_val("ready_a", 32'(ready_a), 32'd1);
    check_val("ready_b", 32'(ready_b), 32'd1);
    @(posedge clk); #1;
    valid_ab = 1'b0;
    repeat (80) @(negedge clk);
    check_val("w1_csn_len", csn_a_lo, 6);
    check_val("w15_csn_len", csn_b_lo, 34);
    check_val("w_ext_rsp_cnt", rsp_ab, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpmc_master.md
GPMC_MASTER -- requirements
Module: gpmc_master

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 2: number of GPMC_CLK data-phase cycles per access; legal range 1..15.
REQ-002 SHALL have port OSC_FPGA, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: an access request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = write access, 0 = read access.
REQ-007 SHALL have port req_addr, input, 16 bits: word address driven in the address phase.
REQ-008 SHALL have port req_wdata, input, 16 bits: write data.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse marking access completion.
REQ-010 SHALL have port rsp_rdata, output, 16 bits: read data, valid while rsp_valid=1.
REQ-011 SHALL have port GPMC_CLK, output, 1 bit: bus clock at OSC_FPGA/2.
REQ-012 SHALL have ports GPMC_CSN, GPMC_ADVN, GPMC_OEN and GPMC_WEN, outputs, 1 bit each: active-low bus strobes.
REQ-013 SHALL have port GPMC_AD, inout, 16 bits: multiplexed address/data bus; released to high-Z when not driven.

Function
REQ-014 GPMC_CLK SHALL be a registered toggle that runs continuously out of reset.
- A "tick" is the OSC_FPGA edge on which GPMC_CLK goes 1->0.
- All bus outputs SHALL change only on ticks, so the responder samples them on the GPMC_CLK rising edge.
REQ-015 req_ready SHALL be 1 only in state IDLE; a request is accepted when req_valid=1 and req_ready=1 on the same edge.
- req_we, req_addr and req_wdata SHALL be captured on that edge.
REQ-016 The state machine SHALL have states IDLE, ADDR, ADDR_HOLD, DATA and TURN; each non-IDLE state lasts a whole number of ticks.
REQ-017 IDLE SHALL drive CSN=1, ADVN=1, OEN=1, WEN=1 and GPMC_AD high-Z.
- On the first tick after acceptance, IDLE SHALL move to ADDR.
REQ-018 ADDR SHALL last 1 tick and drive CSN=0, ADVN=0, GPMC_AD=addr.
REQ-019 ADDR_HOLD SHALL last 1 tick and drive CSN=0, ADVN=1, GPMC_AD=addr.
REQ-020 DATA SHALL last WAIT_CYC ticks, counted by a 4-bit down-counter.
- Write: CSN=0, WEN=0, GPMC_AD=wdata.
- Read: CSN=0, OEN=0, GPMC_AD high-Z.
REQ-021 Read data: on the tick that ends DATA, GPMC_AD SHALL be registered into rsp_rdata.
REQ-022 TURN SHALL last 1 tick with all strobes high and GPMC_AD high-Z, then move to IDLE.
- On the TURN->IDLE edge, rsp_valid SHALL pulse for exactly one OSC_FPGA cycle, for reads and writes alike.
REQ-023 rsp_rdata SHALL hold its last read value until the next read completes; a write SHALL NOT change it.
REQ-024 Access timing:
- From acceptance to CSN falling: 1 or 2 OSC_FPGA cycles, depending on GPMC_CLK phase.
- Total CSN-low time: (2+WAIT_CYC) GPMC_CLK periods.
REQ-025 Back-to-back: a request held valid during TURN SHALL be accepted on the first IDLE edge; CSN SHALL be high for at least 1 GPMC_CLK period between accesses.
REQ-026 Changes to req_* while not in IDLE SHALL be ignored.
REQ-027 GPMC_AD SHALL never be driven by this block in DATA of a read, nor in TURN or IDLE.

Reset
REQ-028 While RESETN=0, outputs SHALL be:
- GPMC_CLK=0, CSN=ADVN=OEN=WEN=1, GPMC_AD high-Z;
- req_ready=0, rsp_valid=0, rsp_rdata=16'h0000;
- state IDLE, counter 0.
REQ-029 Reset asserted mid-access SHALL abort the access immediately, without waiting for an edge.
- No rsp_valid SHALL be produced for the aborted access.
- The first request after RESETN rises SHALL start a clean access from ADDR.
REQ-030 req_ready SHALL rise on the first OSC_FPGA edge after RESETN deasserts.

Structure
REQ-031 Shared package gpmc_pkg SHALL hold:
- the state encoding (IDLE, ADDR, ADDR_HOLD, DATA, TURN);
- the AD width constant (16);
- the default WAIT_CYC.
REQ-032 One sub-module, gpmc_clk_gen, SHALL produce GPMC_CLK and the tick strobe; the FSM, counter and AD tristate stay in gpmc_master.

Verification
REQ-033 Write addr 16'h0010, data 16'hA5A5, WAIT_CYC=2 -> responder model sees:
- ADVN low for 1 period with AD=0010;
- WEN low for 2 periods with AD=A5A5;
- one rsp_valid pulse.
REQ-034 Read addr 16'h0012 with responder returning 16'h1234 -> rsp_valid pulse with rsp_rdata=1234; AD undriven by the block throughout DATA.
REQ-035 Two back-to-back writes (0020/0001, 0022/0002) with req_valid held -> two complete accesses, CSN high ≥1 period between them, two rsp_valid pulses.
REQ-036 RESETN pulsed low during DATA of a write -> outputs immediately at reset values, no rsp_valid; next read of 0012 returns 1234 correctly.
REQ-037 WAIT_CYC=1 and WAIT_CYC=15 -> CSN low for exactly 3 and 17 GPMC_CLK periods respectively.
REQ-038 req_addr and req_wdata changed mid-access -> bus keeps the captured values until TURN.
